// File: rtl/bufr_rd_arb.sv
// bufr_rd_arb: round-robin arbiter and sequencer for the shared
// buffer read port, with empty-wait timeout and error counter.
module bufr_rd_arb #(
  parameter int P_DWIDTH = 8,
  parameter int P_TO_CYC = 16
) (
  input  logic                clk,
  input  logic                rst,
  output logic                buf_ren,
  input  logic [P_DWIDTH-1:0] buf_rdata,
  input  logic                buf_rempty,
  input  logic [1:0]          req,
  output logic [1:0]          ack,
  output logic [P_DWIDTH-1:0] rsp_data,
  output logic                rsp_err,
  output logic [7:0]          err_cnt,
  input  logic                err_clr
);

  localparam int LP_TW =
    (P_TO_CYC > 0) ? $clog2(P_TO_CYC + 1) : 1;
  localparam logic [LP_TW-1:0] LP_TO_LAST =
    LP_TW'(P_TO_CYC);
  localparam logic LP_TO_EN = (P_TO_CYC != 0);

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_WAIT,
    ST_RESP
  } state_t;

  state_t              r_state;
  logic                r_sel;
  logic                r_last_gnt;
  logic [LP_TW-1:0]    r_to_cnt;
  logic [1:0]          r_ack;
  logic [P_DWIDTH-1:0] r_rsp_data;
  logic                r_rsp_err;
  logic [7:0]          r_err_cnt;

  logic       w_in_wait;
  logic       w_req_sel;
  logic       w_to_hit;
  logic       w_to_fail;
  logic       w_win;
  logic [1:0] w_sel_oh;

  assign w_in_wait = (r_state == ST_WAIT);
  assign w_req_sel = req[r_sel];
  assign w_sel_oh  = r_sel ? 2'b10 : 2'b01;

  // The count runs 0..P_TO_CYC, so the failure ack lands
  // P_TO_CYC+2 cycles after the request is first seen.
  assign w_to_hit  = LP_TO_EN && (r_to_cnt == LP_TO_LAST);

  // Data arriving in the expiry cycle takes precedence.
  assign w_to_fail = w_in_wait & w_req_sel
                   & buf_rempty & w_to_hit;

  // Sole requester wins; on contention the one not served last.
  assign w_win = (req[0] & req[1]) ? ~r_last_gnt : req[1];

  assign buf_ren  = w_in_wait & w_req_sel & ~buf_rempty;
  assign ack      = r_ack;
  assign rsp_data = r_rsp_data;
  assign rsp_err  = r_rsp_err;
  assign err_cnt  = r_err_cnt;

  // Grant / wait / respond sequencer with registered response.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state    <= ST_IDLE;
      r_sel      <= 1'b0;
      r_last_gnt <= 1'b1;
      r_to_cnt   <= '0;
      r_ack      <= 2'b00;
      r_rsp_data <= '0;
      r_rsp_err  <= 1'b0;
    end else begin
      r_ack <= 2'b00;
      unique case (r_state)
        ST_IDLE: begin
          if (|req) begin
            r_sel    <= w_win;
            r_to_cnt <= '0;
            r_state  <= ST_WAIT;
          end
        end
        ST_WAIT: begin
          if (!w_req_sel) begin
            r_state <= ST_IDLE;
          end else if (!buf_rempty) begin
            r_rsp_data <= buf_rdata;
            r_rsp_err  <= 1'b0;
            r_ack      <= w_sel_oh;
            r_state    <= ST_RESP;
          end else if (w_to_hit) begin
            r_rsp_data <= '0;
            r_rsp_err  <= 1'b1;
            r_ack      <= w_sel_oh;
            r_state    <= ST_RESP;
          end else begin
            r_to_cnt <= r_to_cnt + LP_TW'(1);
          end
        end
        ST_RESP: begin
          r_last_gnt <= r_sel;
          r_state    <= ST_IDLE;
        end
        default: begin
          r_state <= ST_IDLE;
        end
      endcase
    end
  end

  // Saturating timeout counter; clear beats increment.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_err_cnt <= 8'd0;
    end else if (err_clr) begin
      r_err_cnt <= 8'd0;
    end else if (w_to_fail && !(&r_err_cnt)) begin
      r_err_cnt <= r_err_cnt + 8'd1;
    end
  end

endmodule

// File: tb/tb_bufr_rd_arb.sv
// tb_bufr_rd_arb: vector table plus scoreboard of expected acks
// against a FWFT buffer model and requester model.
module tb_bufr_rd_arb;

  localparam int DW = 8;
  localparam int TO = 16;

  logic          clk = 1'b0;
  logic          rst;
  logic          buf_ren;
  logic [DW-1:0] buf_rdata;
  logic          buf_rempty;
  logic [1:0]    req;
  logic [1:0]    ack;
  logic [DW-1:0] rsp_data;
  logic          rsp_err;
  logic [7:0]    err_cnt;
  logic          err_clr;

  always #5 clk = ~clk;

  bufr_rd_arb #(
    .P_DWIDTH(DW),
    .P_TO_CYC(TO)
  ) dut (
    .clk       (clk),
    .rst       (rst),
    .buf_ren   (buf_ren),
    .buf_rdata (buf_rdata),
    .buf_rempty(buf_rempty),
    .req       (req),
    .ack       (ack),
    .rsp_data  (rsp_data),
    .rsp_err   (rsp_err),
    .err_cnt   (err_cnt),
    .err_clr   (err_clr)
  );

  typedef struct {
    logic [1:0] ack;
    logic [7:0] data;
    logic       err;
    int         at;
  } exp_t;

  typedef struct {
    logic [1:0] rq;
    int         nb;
    logic [7:0] d;
    logic [1:0] eack;
    logic [7:0] edata;
    logic       eerr;
    int         lat;
  } vec_t;

  int         n_tests = 0;
  int         n_fail  = 0;
  int         cyc     = 0;
  int         pops    = 0;
  int         rearm_left = 0;
  int         exp_ec  = 0;
  logic [1:0] rearm   = 2'b00;
  logic [7:0] fifo[$];
  exp_t       sbq[$];
  vec_t       vt[6];

  function automatic void chk(string nm,
                              logic [31:0] act,
                              logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h want %0h (cyc %0d)",
               nm, act, exp, cyc);
    end
  endfunction

  function automatic void expect_rsp(logic [1:0] a,
                                     logic [7:0] d,
                                     logic e, int at);
    exp_t x;
    x.ack  = a;
    x.data = d;
    x.err  = e;
    x.at   = at;
    sbq.push_back(x);
  endfunction

  task automatic upd_buf();
    buf_rempty = (fifo.size() == 0);
    buf_rdata  = buf_rempty ? 8'hEE : fifo[0];
  endtask

  // One clock: sample pop, advance, update buffer, check acks.
  task automatic tick();
    logic r;
    exp_t e;
    #1;
    r = buf_ren;
    if (r) pops++;
    @(posedge clk);
    #1;
    cyc++;
    if (r && fifo.size() > 0) void'(fifo.pop_front());
    upd_buf();
    req   = req | rearm;
    rearm = 2'b00;
    if (ack != 2'b00) begin
      if (sbq.size() == 0) begin
        n_tests++;
        n_fail++;
        $display("FAIL unexpected_ack: got %b want none (cyc %0d)",
                 ack, cyc);
      end else begin
        e = sbq.pop_front();
        chk("ack", 32'(ack), 32'(e.ack));
        chk("rsp_data", 32'(rsp_data), 32'(e.data));
        chk("rsp_err", 32'(rsp_err), 32'(e.err));
        chk("ack_cycle", 32'(cyc), 32'(e.at));
      end
      req = req & ~ack;
      if (rearm_left > 0) begin
        rearm = ack;
        rearm_left--;
      end
    end
  endtask

  task automatic wait_idle(int budget);
    int b;
    b = budget;
    while (sbq.size() > 0 && b > 0) begin
      tick();
      b--;
    end
    if (sbq.size() > 0) begin
      n_tests++;
      n_fail++;
      $display("FAIL ack_timeout: got none want %0d acks",
               sbq.size());
      sbq.delete();
      req = 2'b00;
    end
    tick();
  endtask

  initial begin
    int p0;
    vt[0] = '{2'b01, 1, 8'hA5, 2'b01, 8'hA5, 1'b0, 2};
    vt[1] = '{2'b10, 1, 8'h3C, 2'b10, 8'h3C, 1'b0, 2};
    vt[2] = '{2'b10, 0, 8'h00, 2'b10, 8'h00, 1'b1, TO + 2};
    vt[3] = '{2'b01, 1, 8'hFF, 2'b01, 8'hFF, 1'b0, 2};
    vt[4] = '{2'b01, 0, 8'h00, 2'b01, 8'h00, 1'b1, TO + 2};
    vt[5] = '{2'b10, 1, 8'h00, 2'b10, 8'h00, 1'b0, 2};

    rst     = 1'b1;
    req     = 2'b00;
    err_clr = 1'b0;
    upd_buf();
    @(posedge clk);
    #1;
    tick();
    tick();
    rst = 1'b0;
    chk("rst_ren", 32'(buf_ren), 0);
    chk("rst_ack", 32'(ack), 0);
    chk("rst_data", 32'(rsp_data), 0);
    chk("rst_err", 32'(rsp_err), 0);
    chk("rst_errcnt", 32'(err_cnt), 0);

    // contention: both held, re-raised after each ack
    fifo = '{8'h11, 8'h22, 8'h33, 8'h44};
    upd_buf();
    p0 = pops;
    rearm_left = 2;
    req = 2'b11;
    expect_rsp(2'b01, 8'h11, 1'b0, cyc + 2);
    expect_rsp(2'b10, 8'h22, 1'b0, cyc + 5);
    expect_rsp(2'b01, 8'h33, 1'b0, cyc + 8);
    expect_rsp(2'b10, 8'h44, 1'b0, cyc + 11);
    wait_idle(40);
    chk("cont_pops", 32'(pops - p0), 4);
    chk("cont_req", 32'(req), 0);

    // vector table
    for (int i = 0; i < 6; i++) begin
      p0 = pops;
      if (vt[i].nb > 0) fifo.push_back(vt[i].d);
      upd_buf();
      req = vt[i].rq;
      expect_rsp(vt[i].eack, vt[i].edata,
                 vt[i].eerr, cyc + vt[i].lat);
      if (vt[i].eerr) exp_ec++;
      wait_idle(40);
      chk("vec_pops", 32'(pops - p0), 32'(vt[i].nb));
      chk("vec_errcnt", 32'(err_cnt), 32'(exp_ec));
      chk("vec_hold", 32'(rsp_data), 32'(vt[i].edata));
    end

    // data arrives in the final timeout cycle
    p0 = pops;
    req = 2'b01;
    expect_rsp(2'b01, 8'h5A, 1'b0, cyc + TO + 2);
    repeat (TO + 1) tick();
    fifo.push_back(8'h5A);
    upd_buf();
    wait_idle(10);
    chk("race_pops", 32'(pops - p0), 1);
    chk("race_errcnt", 32'(err_cnt), 32'(exp_ec));

    // abandon on empty buffer, then a normal req1
    p0 = pops;
    req = 2'b01;
    repeat (5) tick();
    req = 2'b00;
    repeat (4) tick();
    chk("abandon_pops", 32'(pops - p0), 0);
    fifo.push_back(8'h77);
    upd_buf();
    req = 2'b10;
    expect_rsp(2'b10, 8'h77, 1'b0, cyc + 2);
    wait_idle(10);
    chk("abandon_errcnt", 32'(err_cnt), 32'(exp_ec));

    // reset while waiting on an empty buffer
    req = 2'b01;
    repeat (3) tick();
    fifo.push_back(8'h99);
    upd_buf();
    rst = 1'b1;
    tick();
    rst = 1'b0;
    chk("mrst_ren", 32'(buf_ren), 0);
    chk("mrst_ack", 32'(ack), 0);
    chk("mrst_data", 32'(rsp_data), 0);
    chk("mrst_err", 32'(rsp_err), 0);
    chk("mrst_errcnt", 32'(err_cnt), 0);
    exp_ec = 0;
    req = 2'b00;
    fifo.delete();
    upd_buf();
    repeat (4) tick();

    // saturate the error counter
    for (int i = 0; i < 256; i++) begin
      req = 2'b10;
      expect_rsp(2'b10, 8'h00, 1'b1, cyc + TO + 2);
      wait_idle(30);
      if (exp_ec < 255) exp_ec++;
      if (i >= 254) chk("sat_errcnt", 32'(err_cnt), 32'(exp_ec));
    end

    // clear coincident with a timeout
    req = 2'b01;
    expect_rsp(2'b01, 8'h00, 1'b1, cyc + TO + 2);
    repeat (TO + 1) tick();
    err_clr = 1'b1;
    tick();
    err_clr = 1'b0;
    chk("clr_errcnt", 32'(err_cnt), 0);
    wait_idle(10);

    chk("sb_drain", 32'(sbq.size()), 0);
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
